// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 sliding-window convolution sequencer.
package conv_pkg;

   localparam int KSIZE = 3;
   localparam int TAP_W = 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_COMPUTE,
      S_CAPTURE,
      S_OUTPUT
   } state_t;

   typedef logic [TAP_W-1:0] tap_t;

   function automatic tap_t tap_max();
      return tap_t'(KSIZE - 1);
   endfunction

endpackage

// File: rtl/conv_addr_gen.sv
// Window and tap counters for the sequencer; mem_addr is registered together
// with the counters so it always names the tap the counters point at.
module conv_addr_gen
   import conv_pkg::*;
#(
   parameter int IMG_W  = 8,
   parameter int IMG_H  = 8,
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              tap_step,
   input  logic              win_step,
   output logic [ADDR_W-1:0] addr,
   output logic [TAP_W-1:0]  tap_i,
   output logic [TAP_W-1:0]  tap_j,
   output logic              last_tap,
   output logic              last_window
);

   localparam int ROW_W = $clog2(IMG_H);
   localparam int COL_W = $clog2(IMG_W);

   logic [ROW_W-1:0]  win_r;
   logic [ROW_W-1:0]  win_r_n;
   logic [COL_W-1:0]  win_c;
   logic [COL_W-1:0]  win_c_n;
   logic [TAP_W-1:0]  tap_i_n;
   logic [TAP_W-1:0]  tap_j_n;
   logic [ADDR_W-1:0] addr_n;

   // The address is derived from the next counter values so the registered
   // copy is ready on the very cycle the new tap or window becomes current.
   always_comb begin
      win_r_n = win_r;
      win_c_n = win_c;
      tap_i_n = tap_i;
      tap_j_n = tap_j;
      if (clear) begin
         win_r_n = '0;
         win_c_n = '0;
         tap_i_n = '0;
         tap_j_n = '0;
      end else begin
         if (tap_step) begin
            if (tap_j == tap_max()) begin
               tap_j_n = '0;
               tap_i_n = (tap_i == tap_max()) ? '0 : tap_i + 1'b1;
            end else begin
               tap_j_n = tap_j + 1'b1;
            end
         end
         if (win_step) begin
            if (win_c == COL_W'(IMG_W - KSIZE)) begin
               win_c_n = '0;
               win_r_n = win_r + 1'b1;
            end else begin
               win_c_n = win_c + 1'b1;
            end
         end
      end
      addr_n = (ADDR_W'(win_r_n) + ADDR_W'(tap_i_n)) * ADDR_W'(IMG_W)
             + ADDR_W'(win_c_n) + ADDR_W'(tap_j_n);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         win_r <= '0;
         win_c <= '0;
         tap_i <= '0;
         tap_j <= '0;
         addr  <= '0;
      end else begin
         win_r <= win_r_n;
         win_c <= win_c_n;
         tap_i <= tap_i_n;
         tap_j <= tap_j_n;
         addr  <= addr_n;
      end
   end

   assign last_tap    = (tap_i == tap_max()) && (tap_j == tap_max());
   assign last_window = (win_r == ROW_W'(IMG_H - KSIZE)) &&
                        (win_c == COL_W'(IMG_W - KSIZE));

endmodule

// File: rtl/conv_seq.sv
// Frame sequencer: streams every 3x3 window of a pixel memory into an
// external convolution engine and hands each result out over valid/ready.
module conv_seq
   import conv_pkg::*;
#(
   parameter int IMG_W  = 8,
   parameter int IMG_H  = 8,
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_rdata,
   output logic              conv_load,
   output logic [TAP_W-1:0]  conv_row,
   output logic [TAP_W-1:0]  conv_col,
   output logic [7:0]        conv_data,
   input  logic [7:0]        conv_out,
   output logic              res_valid,
   output logic [7:0]        res_data,
   output logic              res_last,
   input  logic              res_ready,
   output logic              done
);

   state_t           state;
   logic             clear;
   logic             tap_step;
   logic             win_step;
   logic [TAP_W-1:0] tap_i;
   logic [TAP_W-1:0] tap_j;
   logic             last_tap;
   logic             last_window;

   assign clear    = (state == S_IDLE) && start;
   assign tap_step = (state == S_LOAD) && mem_rd_en;
   assign win_step = (state == S_OUTPUT) && res_ready && !last_window;

   conv_addr_gen #(
      .IMG_W  (IMG_W),
      .IMG_H  (IMG_H),
      .ADDR_W (ADDR_W)
   ) u_addr_gen (
      .clk         (clk),
      .rst         (rst),
      .clear       (clear),
      .tap_step    (tap_step),
      .win_step    (win_step),
      .addr        (mem_addr),
      .tap_i       (tap_i),
      .tap_j       (tap_j),
      .last_tap    (last_tap),
      .last_window (last_window)
   );

   // Each tap write trails its memory read by one cycle, so conv_load and the
   // tap coordinates are simply the read strobe and counters delayed a cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         mem_rd_en <= 1'b0;
         conv_load <= 1'b0;
         conv_row  <= '0;
         conv_col  <= '0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_last  <= 1'b0;
         done      <= 1'b0;
      end else begin
         done      <= 1'b0;
         conv_load <= mem_rd_en;
         conv_row  <= mem_rd_en ? tap_i : '0;
         conv_col  <= mem_rd_en ? tap_j : '0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state     <= S_LOAD;
                  mem_rd_en <= 1'b1;
               end
            end
            S_LOAD: begin
               if (mem_rd_en) begin
                  if (last_tap) begin
                     mem_rd_en <= 1'b0;
                  end
               end else begin
                  state <= S_COMPUTE;
               end
            end
            S_COMPUTE: begin
               state <= S_CAPTURE;
            end
            S_CAPTURE: begin
               res_data  <= conv_out;
               res_valid <= 1'b1;
               res_last  <= last_window;
               state     <= S_OUTPUT;
            end
            S_OUTPUT: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  res_last  <= 1'b0;
                  if (last_window) begin
                     state <= S_IDLE;
                     done  <= 1'b1;
                  end else begin
                     state     <= S_LOAD;
                     mem_rd_en <= 1'b1;
                  end
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign busy      = (state != S_IDLE);
   assign conv_data = conv_load ? mem_rdata : 8'd0;

endmodule
